// File: rtl/window_extrema_tracker_if.sv
// Sample-in / result-out bundle for window_extrema_tracker.
// The master side is the environment; the slave side is the tracker itself.
interface window_extrema_tracker_if #(
    parameter int WIDTH   = 4,
    parameter int WIN_LEN = 8,
    parameter int IDX_W   = $clog2(WIN_LEN),
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_max_hits;
    logic [WIDTH-1:0] out_min;
    logic             busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_max_idx, out_max_hits, out_min, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_max_idx, out_max_hits, out_min, busy
    );
endinterface

// File: rtl/window_extrema_tracker.sv
// Collects WIN_LEN unsigned samples and reports max, first max index, max hit
// count and min through a valid/ready result handshake.
module window_extrema_tracker #(
    parameter int WIDTH   = 4,
    parameter int WIN_LEN = 8,
    parameter int IDX_W   = $clog2(WIN_LEN),
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    window_extrema_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [WIDTH-1:0] max_q, min_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] hits_q;

    // Returns {a > b, a == b}, resolved at the first differing bit from the MSB,
    // matching the upstream magnitude-compare path.
    function automatic logic [1:0] cmp_msb(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                gt      = a[i];
            end
        end
        return {gt, !decided};
    endfunction

    logic [1:0] max_cmp, min_cmp;
    logic       accept, last;

    assign max_cmp = cmp_msb(bus.in_data, max_q);
    assign min_cmp = cmp_msb(min_q, bus.in_data);
    assign accept  = (state_q == COLLECT) && bus.in_valid;
    assign last    = (cnt_q == IDX_W'(WIN_LEN - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)            state_d = COLLECT;
            COLLECT: if (accept && last)       state_d = DONE;
            DONE:    if (bus.out_ready)        state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // NOTE: result registers are reset too, so outputs read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            max_q  <= '0;
            min_q  <= '0;
            idx_q  <= '0;
            hits_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            cnt_q <= '0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                max_q  <= bus.in_data;
                min_q  <= bus.in_data;
                idx_q  <= '0;
                hits_q <= CNT_W'(1);
            end else begin
                if (max_cmp[1]) begin
                    max_q  <= bus.in_data;
                    idx_q  <= cnt_q;
                    hits_q <= CNT_W'(1);
                end else if (max_cmp[0]) begin
                    hits_q <= hits_q + 1'b1;
                end
                if (min_cmp[1]) min_q <= bus.in_data;
            end
            // Hold at WIN_LEN-1 so a power-of-two window never wraps the counter.
            if (!last) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready     = (state_q == COLLECT);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.out_max      = max_q;
    assign bus.out_max_idx  = idx_q;
    assign bus.out_max_hits = hits_q;
    assign bus.out_min      = min_q;
endmodule

// File: tb/tb_window_extrema_tracker.sv
// Self-checking bench for window_extrema_tracker (WIDTH=4, WIN_LEN=8).
module tb_window_extrema_tracker;
    localparam int WIDTH   = 4;
    localparam int WIN_LEN = 8;

    logic clk;
    logic rst_n;

    window_extrema_tracker_if #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN)) bus ();

    window_extrema_tracker #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:7][3:0] s;
        int              gap;
        logic [3:0]      max;
        logic [2:0]      idx;
        logic [3:0]      hits;
        logic [3:0]      min;
    } vec_t;

    typedef struct {
        logic [3:0] max;
        logic [2:0] idx;
        logic [3:0] hits;
        logic [3:0] min;
    } res_t;

    res_t sb[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_max"},       32'(bus.out_max), 0);
        check({tag, "_idx"},       32'(bus.out_max_idx), 0);
        check({tag, "_hits"},      32'(bus.out_max_hits), 0);
        check({tag, "_min"},       32'(bus.out_min), 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
    endtask

    // Drives one full window; start is also pulsed with sample start_at (if >= 0).
    task automatic send_window(input vec_t v, input int start_at);
        res_t r;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (v.gap > 0) begin
                repeat ($urandom_range(v.gap, 0)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 4'd0;
                    check("ready_in_gap", 32'(bus.in_ready), 1);
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v.s[i];
            bus.start    = (i == start_at);
            check("ready_collect", 32'(bus.in_ready), 1);
            if (i == WIN_LEN - 1) begin
                r.max = v.max; r.idx = v.idx; r.hits = v.hits; r.min = v.min;
                sb.push_back(r);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    // Expects out_valid one clock after the last accept, then holds and completes the handshake.
    task automatic collect_result(input int hold);
        res_t e;
        int   waited;
        check("latency_out_valid", 32'(bus.out_valid), 1);
        waited = 0;
        while (!bus.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'(bus.out_valid), 1);
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("max",  32'(bus.out_max), 32'(e.max));
        check("idx",  32'(bus.out_max_idx), 32'(e.idx));
        check("hits", 32'(bus.out_max_hits), 32'(e.hits));
        check("min",  32'(bus.out_min), 32'(e.min));
        for (int c = 0; c < hold; c++) begin
            bus.out_ready = 1'b0;
            bus.start     = (c == 2);
            @(negedge clk);
            check("hold_valid",    32'(bus.out_valid), 1);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_max",      32'(bus.out_max), 32'(e.max));
            check("hold_hits",     32'(bus.out_max_hits), 32'(e.hits));
            check("hold_min",      32'(bus.out_min), 32'(e.min));
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 0);
        check("post_busy",  32'(bus.busy), 0);
        check("post_max",   32'(bus.out_max), 32'(e.max));
        check("post_idx",   32'(bus.out_max_idx), 32'(e.idx));
        @(negedge clk);
        check("idle_busy",  32'(bus.busy), 0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{s: {4'd3, 4'd9, 4'd2, 4'd9, 4'd15, 4'd0, 4'd15, 4'd7}, gap: 0,
                    max: 4'd15, idx: 3'd4, hits: 4'd2, min: 4'd0};
        vecs[1] = '{s: {8{4'd5}}, gap: 3,
                    max: 4'd5, idx: 3'd0, hits: 4'd8, min: 4'd5};
        vecs[2] = '{s: {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8}, gap: 0,
                    max: 4'd15, idx: 3'd0, hits: 4'd1, min: 4'd8};
        vecs[3] = '{s: {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7}, gap: 1,
                    max: 4'd7, idx: 3'd7, hits: 4'd1, min: 4'd0};
        vecs[4] = '{s: {4'd0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd15, 4'd0, 4'd15}, gap: 2,
                    max: 4'd15, idx: 3'd1, hits: 4'd4, min: 4'd0};

        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // in_valid ignored in IDLE
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd6;
        @(negedge clk);
        check("idle_ready", 32'(bus.in_ready), 0);
        check("idle_busy0", 32'(bus.busy), 0);
        bus.in_valid = 1'b0;

        // First window also exercises a held result with start pulsed in DONE.
        for (int k = 0; k < 5; k++) begin
            do_start();
            send_window(vecs[k], -1);
            collect_result(k == 0 ? 5 : 0);
        end

        // in_valid already high during the start cycle: first COLLECT cycle accepts.
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[2].s[0];
        do_start();
        send_window(vecs[2], -1);
        collect_result(0);

        // start mid-COLLECT after 3 accepts is ignored.
        v = '{s: {4'd4, 4'd6, 4'd1, 4'd6, 4'd2, 4'd9, 4'd3, 4'd9}, gap: 0,
              max: 4'd9, idx: 3'd5, hits: 4'd2, min: 4'd1};
        do_start();
        send_window(v, 3);
        collect_result(0);

        // Asynchronous reset after 4 accepts.
        do_start();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 2) ? 4'd0 : 4'd15;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst_collect");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{s: {8{4'd1}}, gap: 0, max: 4'd1, idx: 3'd0, hits: 4'd8, min: 4'd1};
        do_start();
        send_window(v, -1);
        collect_result(0);

        // Asynchronous reset in DONE discards the pending result.
        do_start();
        send_window(vecs[0], -1);
        check("done_before_rst", 32'(bus.out_valid), 1);
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst_done");
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/window_extrema_tracker.md
Name: window_extrema_tracker

Overview:
- Streaming consumer of unsigned WIDTH-bit samples. Collects a window of WIN_LEN samples and reports the window maximum, its first index, its hit count, and the window minimum.
- Sits directly downstream of the team's magnitude-compare path. Internally it relies only on greater-than and equal decisions, evaluated MSB-first in the same way as that path.
- Presents one result per window through a valid/ready output handshake.

Parameters:
- WIDTH, 4, sample width in bits (unsigned).
- WIN_LEN, 8, samples per window (≥2).
- IDX_W, $clog2(WIN_LEN), width of index fields.
- CNT_W, $clog2(WIN_LEN+1), width of hit-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; opens a new window (honoured in IDLE only).
- in_valid  in  1  sample present on in_data.
- in_data  in  WIDTH  sample.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  result fields valid.
- out_ready  in  1  downstream takes the result.
- out_max  out  WIDTH  window maximum.
- out_max_idx  out  IDX_W  index (0-based) of the first sample equal to the maximum.
- out_max_hits  out  CNT_W  number of samples equal to the maximum.
- out_min  out  WIDTH  window minimum.
- busy  out  1  high in COLLECT or DONE.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE.
  - All outputs and internal registers are 0: in_ready, out_valid, busy, out_max, out_max_idx, out_max_hits, out_min, sample counter.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 → COLLECT next cycle; sample counter cleared to 0.
- COLLECT:
  - in_ready=1; busy=1. A sample is accepted on any cycle with in_valid & in_ready.
  - First accepted sample (counter=0): max=min=sample, max_idx=0, max_hits=1.
  - Each later sample s at index k:
    - s > max → max=s, max_idx=k, max_hits=1.
    - s == max → max_hits+1; max_idx unchanged (the first occurrence wins).
    - s < min → min=s. This check is independent of the max update.
  - On the WIN_LEN-th acceptance, the last sample is folded in on that same edge → DONE next cycle.
  - Latency from the last accepted sample to out_valid=1 is one clock.
  - Gaps (in_valid=0) are allowed without limit; no state change occurs during a gap.
  - start in COLLECT is ignored; the window is not restarted.
- DONE:
  - out_valid=1; in_ready=0; result fields hold stable until the handshake.
  - out_valid & out_ready → IDLE next cycle; out_valid drops, and result fields keep their last values.
  - start in DONE is ignored. A new window needs start in IDLE, so there is a minimum of one IDLE cycle between windows.
- Arithmetic:
  - All compares are unsigned over the full WIDTH.
  - The counter runs 0..WIN_LEN-1 and never wraps inside a window.
  - max_hits saturates naturally at WIN_LEN, since CNT_W covers that value.
- Boundary cases:
  - All samples equal v → out_max=out_min=v, idx=0, hits=WIN_LEN.
  - Extremes 0 and 2^WIDTH-1 must compare correctly, with no sign interpretation.
  - Asynchronous reset mid-COLLECT or mid-DONE discards the window. Outputs return to reset values immediately, without waiting for clk.
  - in_valid held high when entering COLLECT: a sample is accepted on the first COLLECT cycle.

Test Plan:
- Reset then start, WIDTH=4, WIN_LEN=8, samples 3,9,2,9,15,0,15,7 back-to-back → out_valid 1 cycle after the 8th accept; max=15, idx=4, hits=2, min=0.
- All samples 5 with random in_valid gaps → max=5, min=5, idx=0, hits=8. in_ready=1 throughout COLLECT; no acceptance while in_valid=0.
- Strictly descending 15..8 → max=15, idx=0, hits=1, min=8. Strictly ascending 0..7 → max=7, idx=7, hits=1, min=0.
- Result in DONE with out_ready=0 for 5 cycles, start pulsed during that time → fields stable, in_ready=0, start ignored. out_ready=1 → IDLE next cycle.
- rst_n asserted after 4 accepts → all outputs 0 asynchronously. New start plus 8 samples of 1 → max=min=1, hits=8, with no leftover state from the discarded window.
- start pulsed in COLLECT after 3 accepts → ignored; window completes after 5 more accepts with correct extrema.
